// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: IDLE/RUN/HALTED control with branch, stall and restart.
// Optional taken-branch counter on Taken_cnt when FETCH_BRANCH_COUNT_EN is defined.
module fetch_unit #(
  parameter int          PC_W       = 10,
  parameter int unsigned START_ADDR = 0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            Branch_en,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            Fetch_valid,
  output logic            Done,
  output logic [15:0]     Taken_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  state_e          state, state_next;
  logic [PC_W-1:0] pc_q, pc_next;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    unique case (state)
      IDLE: begin
        if (Start) begin
          pc_next    = START_PC;
          state_next = RUN;
        end
      end
      RUN: begin
        if (Start) begin
          pc_next = START_PC;
        end else if (Stall) begin
          pc_next = pc_q;
        end else if (Halt) begin
          state_next = HALTED;
        end else if (Branch_en) begin
          pc_next = Target;
        end else begin
          pc_next = pc_q + PC_W'(1);
        end
      end
      HALTED: begin
        if (Start) begin
          pc_next    = START_PC;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
        pc_next    = START_PC;
      end
    endcase
  end

  // NOTE: reset is sampled at the clock edge (synchronous) and state uses non-blocking
  // assignments so every flop sees pre-edge values.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      pc_q  <= START_PC;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
    end
  end

  assign PC          = pc_q;
  assign Fetch_valid = (state == RUN);
  assign Done        = (state == HALTED);

`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] taken_q;
  logic        branch_taken;

  // A branch only counts when it actually redirects the PC.
  assign branch_taken = (state == RUN) && Branch_en && !Start && !Stall && !Halt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      taken_q <= '0;
    end else if (Start) begin
      taken_q <= '0;
    end else if (branch_taken && (taken_q != 16'hFFFF)) begin
      taken_q <= taken_q + 16'd1;
    end
  end

  assign Taken_cnt = taken_q;
`else
  assign Taken_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed cycles push expected outputs, a negedge monitor compares.
module tb_fetch_unit;

  localparam int PC_W = 10;
`ifdef FETCH_BRANCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            Clk = 1'b0;
  logic            Reset_n, Start, Stall, Halt, Branch_en;
  logic [PC_W-1:0] Target;
  logic [PC_W-1:0] PC;
  logic            Fetch_valid, Done;
  logic [15:0]     Taken_cnt;

  fetch_unit #(.PC_W(PC_W), .START_ADDR(0)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Stall      (Stall),
    .Halt       (Halt),
    .Branch_en  (Branch_en),
    .Target     (Target),
    .PC         (PC),
    .Fetch_valid(Fetch_valid),
    .Done       (Done),
    .Taken_cnt  (Taken_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string           name;
    logic [PC_W-1:0] pc;
    logic            fv;
    logic            done;
    logic [15:0]     cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, queue the outputs expected after the next rising edge.
  task automatic cyc(input string name, input logic rst_n, input logic st, input logic sl,
                     input logic hl, input logic br, input logic [PC_W-1:0] tgt,
                     input logic [PC_W-1:0] e_pc, input logic e_fv, input logic e_done,
                     input logic [15:0] e_cnt);
    exp_t e;
    Reset_n = rst_n; Start = st; Stall = sl; Halt = hl; Branch_en = br; Target = tgt;
    e.name = name; e.pc = e_pc; e.fv = e_fv; e.done = e_done; e.cnt = CNT_EN ? e_cnt : 16'd0;
    sb.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  // Monitor: outputs settle after the rising edge; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".pc"},   32'(PC),          32'(e.pc));
        check({e.name, ".fv"},   32'(Fetch_valid), 32'(e.fv));
        check({e.name, ".done"}, 32'(Done),        32'(e.done));
        check({e.name, ".cnt"},  32'(Taken_cnt),   32'(e.cnt));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //    name          rst st sl hl br target   pc     fv done cnt
    cyc("reset0",      0, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    cyc("reset1",      0, 0, 0, 0, 1, 10'h123, 10'h000, 0, 0, 0);
    cyc("idle_ign",    1, 0, 1, 1, 1, 10'h155, 10'h000, 0, 0, 0);
    cyc("start",       1, 1, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    cyc("inc1",        1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    cyc("inc2",        1, 0, 0, 0, 0, 10'h000, 10'h002, 1, 0, 0);
    cyc("inc3",        1, 0, 0, 0, 0, 10'h000, 10'h003, 1, 0, 0);
    cyc("stall_a",     1, 0, 1, 0, 1, 10'h100, 10'h003, 1, 0, 0);
    cyc("stall_b",     1, 0, 1, 0, 1, 10'h100, 10'h003, 1, 0, 0);
    cyc("stall_c",     1, 0, 1, 0, 1, 10'h100, 10'h003, 1, 0, 0);
    cyc("stall_rel",   1, 0, 0, 0, 0, 10'h100, 10'h004, 1, 0, 0);
    cyc("inc5",        1, 0, 0, 0, 0, 10'h000, 10'h005, 1, 0, 0);
    cyc("branch40",    1, 0, 0, 0, 1, 10'h040, 10'h040, 1, 0, 1);
    cyc("after_br",    1, 0, 0, 0, 0, 10'h000, 10'h041, 1, 0, 1);
    cyc("branch7",     1, 0, 0, 0, 1, 10'h007, 10'h007, 1, 0, 2);
    cyc("halt_br",     1, 0, 0, 1, 1, 10'h100, 10'h007, 0, 1, 2);
    cyc("halted_a",    1, 0, 1, 1, 1, 10'h100, 10'h007, 0, 1, 2);
    cyc("halted_b",    1, 0, 0, 0, 0, 10'h000, 10'h007, 0, 1, 2);
    cyc("restart",     1, 1, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    cyc("rs_inc",      1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    cyc("stall_halt",  1, 0, 1, 1, 0, 10'h000, 10'h001, 1, 0, 0);
    cyc("start_br",    1, 1, 0, 0, 1, 10'h2AA, 10'h000, 1, 0, 0);
    cyc("start_hold",  1, 1, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    cyc("wrap_br",     1, 0, 0, 0, 1, 10'h3FF, 10'h3FF, 1, 0, 1);
    cyc("wrap0",       1, 0, 0, 0, 0, 10'h000, 10'h000, 1, 0, 1);
    cyc("wrap1",       1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 1);
    cyc("self_loop",   1, 0, 0, 0, 1, 10'h001, 10'h001, 1, 0, 2);
    cyc("br20",        1, 0, 0, 0, 1, 10'h020, 10'h020, 1, 0, 3);
    cyc("rst_mid",     0, 0, 0, 0, 1, 10'h055, 10'h000, 0, 0, 0);
    cyc("post_rst_a",  1, 0, 0, 0, 1, 10'h055, 10'h000, 0, 0, 0);
    cyc("post_rst_b",  1, 0, 0, 0, 0, 10'h000, 10'h000, 0, 0, 0);
    cyc("start2",      1, 1, 0, 0, 0, 10'h000, 10'h000, 1, 0, 0);
    cyc("start2_inc",  1, 0, 0, 0, 0, 10'h000, 10'h001, 1, 0, 0);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
